// File: rtl/regfile_mp.sv
// Multi-port integer register file: NUM_RD combinational reads, two prioritised write ports, per-register busy scoreboard.
// Optional read-port forwarding of same-cycle writes is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 32,
    parameter int NUM_RD  = 2,
    parameter int SP_IDX  = 2,
    parameter int SP_INIT = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_RD*$clog2(DEPTH)-1:0] rd_addr,
    output logic [NUM_RD*XLEN-1:0]     rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       wr0_en,
    input  logic [$clog2(DEPTH)-1:0]   wr0_addr,
    input  logic [XLEN-1:0]            wr0_data,
    input  logic                       wr1_en,
    input  logic [$clog2(DEPTH)-1:0]   wr1_addr,
    input  logic [XLEN-1:0]            wr1_data,
    input  logic                       iss_en,
    input  logic [$clog2(DEPTH)-1:0]   iss_addr
);
    localparam int AW = $clog2(DEPTH);

    logic [XLEN-1:0]  regs_q [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Register 0 is reset to zero and never written, so it reads 0 with no extra mux.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= (i == SP_IDX && i != 0) ? XLEN'(SP_INIT) : '0;
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (wr0_en && wr0_addr == AW'(i)) begin
                    regs_q[i] <= wr0_data;
                end else if (wr1_en && wr1_addr == AW'(i)) begin
                    regs_q[i] <= wr1_data;
                end
            end
        end
    end

    // A new issue wins over a retiring write so the younger producer stays tracked.
    always_comb begin
        busy_d = busy_q;
        busy_d[0] = 1'b0;
        for (int i = 1; i < DEPTH; i++) begin
            if (iss_en && iss_addr == AW'(i)) begin
                busy_d[i] = 1'b1;
            end else if ((wr0_en && wr0_addr == AW'(i)) || (wr1_en && wr1_addr == AW'(i))) begin
                busy_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0] ra;
        assign ra = rd_addr[p*AW +: AW];
`ifdef REGFILE_BYPASS_EN
        logic hit0;
        logic hit1;
        logic iss_hit;
        assign hit0    = wr0_en && wr0_addr == ra && ra != '0;
        assign hit1    = wr1_en && wr1_addr == ra && ra != '0;
        assign iss_hit = iss_en && iss_addr == ra;
        always_comb begin
            rd_data[p*XLEN +: XLEN] = regs_q[ra];
            rd_busy[p]              = busy_q[ra];
            if (hit0) begin
                rd_data[p*XLEN +: XLEN] = wr0_data;
            end else if (hit1) begin
                rd_data[p*XLEN +: XLEN] = wr1_data;
            end
            if ((hit0 || hit1) && !iss_hit) begin
                rd_busy[p] = 1'b0;
            end
        end
`else
        assign rd_data[p*XLEN +: XLEN] = regs_q[ra];
        assign rd_busy[p]              = busy_q[ra];
`endif
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp (default parameters, two read ports).
module tb_regfile_mp;
    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic              clk;
    logic              rst_n;
    logic [2*AW-1:0]   rd_addr;
    logic [2*XLEN-1:0] rd_data;
    logic [1:0]        rd_busy;
    logic              wr0_en;
    logic [AW-1:0]     wr0_addr;
    logic [XLEN-1:0]   wr0_data;
    logic              wr1_en;
    logic [AW-1:0]     wr1_addr;
    logic [XLEN-1:0]   wr1_data;
    logic              iss_en;
    logic [AW-1:0]     iss_addr;

    int vectors = 0;
    int errs    = 0;

    regfile_mp dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr0_en   (wr0_en),
        .wr0_addr (wr0_addr),
        .wr0_data (wr0_data),
        .wr1_en   (wr1_en),
        .wr1_addr (wr1_addr),
        .wr1_data (wr1_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wr0_en = 1'b0;
        wr1_en = 1'b0;
        iss_en = 1'b0;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    // Drive a write/issue pattern for exactly one posedge, then go idle mid-cycle.
    task automatic commit();
        @(posedge clk);
        @(negedge clk);
        idle();
        #1;
    endtask

    initial begin
        rst_n    = 1'b1;
        rd_addr  = '0;
        wr0_en   = 1'b0; wr0_addr = '0; wr0_data = '0;
        wr1_en   = 1'b0; wr1_addr = '0; wr1_data = '0;
        iss_en   = 1'b0; iss_addr = '0;
        #2 rst_n = 1'b0;
        set_rd(5'd2, 5'd5);
        #1;
        check("reset_sp",    rd_data[31:0],  32'd255);
        check("reset_x5",    rd_data[63:32], 32'd0);
        check("reset_busy",  {30'd0, rd_busy}, 32'd0);
        #10 rst_n = 1'b1;

        // Reset release, then plain write and dual-port read
        @(negedge clk);
        #1;
        check("post_rst_sp", rd_data[31:0], 32'd255);
        wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEADBEEF;
        commit();
        set_rd(5'd5, 5'd5);
        #1;
        check("x5_port0", rd_data[31:0],  32'hDEADBEEF);
        check("x5_port1", rd_data[63:32], 32'hDEADBEEF);

        wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'h1234;
        commit();
        set_rd(5'd0, 5'd5);
        #1;
        check("x0_reads_0", rd_data[31:0], 32'd0);

        // Write-port priority and wr1 alone
        wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'hA;
        wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'hB;
        commit();
        wr1_en = 1'b1; wr1_addr = 5'd8; wr1_data = 32'hC;
        commit();
        set_rd(5'd7, 5'd8);
        #1;
        check("x7_wr0_wins", rd_data[31:0],  32'hA);
        check("x8_wr1",      rd_data[63:32], 32'hC);

        // Scoreboard
        iss_en = 1'b1; iss_addr = 5'd9;
        commit();
        set_rd(5'd9, 5'd8);
        #1;
        check("x9_busy_set", {31'd0, rd_busy[0]}, 32'd1);
        check("x8_not_busy", {31'd0, rd_busy[1]}, 32'd0);
        wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 32'h11;
        commit();
        check("x9_busy_clr", {31'd0, rd_busy[0]}, 32'd0);
        check("x9_data_11",  rd_data[31:0], 32'h11);
        iss_en = 1'b1; iss_addr = 5'd9;
        wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'h22;
        commit();
        check("x9_iss_wb_busy", {31'd0, rd_busy[0]}, 32'd1);
        check("x9_iss_wb_data", rd_data[31:0], 32'h22);
        iss_en = 1'b1; iss_addr = 5'd9;
        commit();
        check("x9_reissue_busy", {31'd0, rd_busy[0]}, 32'd1);
        iss_en = 1'b1; iss_addr = 5'd0;
        commit();
        set_rd(5'd0, 5'd9);
        #1;
        check("x0_never_busy", {31'd0, rd_busy[0]}, 32'd0);

        // Same-cycle write visibility
        set_rd(5'd3, 5'd8);
        wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'h55;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("x3_same_cycle", rd_data[31:0], 32'h55);
`else
        check("x3_same_cycle", rd_data[31:0], 32'h0);
`endif
        commit();
        check("x3_next_cycle", rd_data[31:0], 32'h55);

        iss_en = 1'b1; iss_addr = 5'd10;
        commit();
        set_rd(5'd10, 5'd8);
        wr1_en = 1'b1; wr1_addr = 5'd10; wr1_data = 32'h77;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("x10_fwd_data", rd_data[31:0], 32'h77);
        check("x10_fwd_busy", {31'd0, rd_busy[0]}, 32'd0);
`else
        check("x10_fwd_data", rd_data[31:0], 32'h0);
        check("x10_fwd_busy", {31'd0, rd_busy[0]}, 32'd1);
`endif
        commit();
        check("x10_after", rd_data[31:0], 32'h77);
        check("x10_after_busy", {31'd0, rd_busy[0]}, 32'd0);

        // Stack pointer is an ordinary writable register after reset
        wr1_en = 1'b1; wr1_addr = 5'd2; wr1_data = 32'h1000;
        commit();
        set_rd(5'd4, 5'd2);
        #1;
        check("sp_written", rd_data[63:32], 32'h1000);

        // Mid-cycle async reset with a write pending
        iss_en = 1'b1; iss_addr = 5'd4;
        wr0_en = 1'b1; wr0_addr = 5'd4; wr0_data = 32'h99;
        commit();
        check("x4_data_99", rd_data[31:0], 32'h99);
        check("x4_busy",    {31'd0, rd_busy[0]}, 32'd1);
        wr0_en = 1'b1; wr0_addr = 5'd4; wr0_data = 32'h123;
        #1 rst_n = 1'b0;
        #1;
        check("rst_x4_data", rd_data[31:0],  32'd0);
        check("rst_x4_busy", {31'd0, rd_busy[0]}, 32'd0);
        check("rst_sp",      rd_data[63:32], 32'd255);
        @(posedge clk);
        #1;
        check("rst_write_lost", rd_data[31:0], 32'd0);
        idle();
        rst_n = 1'b1;
        set_rd(5'd5, 5'd9);
        #1;
        check("rst_x5_clr",   rd_data[31:0], 32'd0);
        check("rst_x9_idle",  {31'd0, rd_busy[1]}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
